// File: rtl/pes_elevator_pkg.sv
// rtl/pes_elevator_pkg.sv - shared types and one-hot helpers for the elevator call scheduler
package pes_elevator_pkg;

  localparam int NFLOORS_DEF = 8;
  // Helpers work on a fixed 32-bit container; callers zero-extend narrower vectors.
  localparam int VEC_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RETIRE = 2'd2
  } state_e;

  function automatic logic onehot_ok(input logic [VEC_W-1:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

  function automatic logic [4:0] oh_to_idx(input logic [VEC_W-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < VEC_W; i++) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  function automatic logic [VEC_W-1:0] idx_to_oh(input logic [4:0] idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/pes_elevator_scan_pick.sv
// rtl/pes_elevator_scan_pick.sv - combinational SCAN picker: next target floor and travel direction
module pes_elevator_scan_pick
  import pes_elevator_pkg::*;
#(
  parameter int NFLOORS = NFLOORS_DEF,
  parameter int IW      = 3
) (
  input  logic [NFLOORS-1:0] pending,
  input  logic [IW-1:0]      cur_idx,
  input  logic               dir_up,
  output logic [NFLOORS-1:0] pick_oh,
  output logic               new_dir_up,
  output logic               any
);

  logic          up_found;
  logic          dn_found;
  logic          here_hit;
  logic [IW-1:0] up_idx;
  logic [IW-1:0] dn_idx;
  logic [IW-1:0] pick_idx;

  always_comb begin
    up_found = 1'b0;
    dn_found = 1'b0;
    up_idx   = '0;
    dn_idx   = '0;
    // Descending scan leaves the lowest index above cur; ascending leaves the highest below.
    for (int i = NFLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (i > int'(cur_idx))) begin
        up_found = 1'b1;
        up_idx   = IW'(i);
      end
    end
    for (int i = 0; i < NFLOORS; i++) begin
      if (pending[i] && (i < int'(cur_idx))) begin
        dn_found = 1'b1;
        dn_idx   = IW'(i);
      end
    end

    here_hit = (int'(cur_idx) < NFLOORS) ? pending[cur_idx] : 1'b0;
    any      = |pending;

    pick_idx   = cur_idx;
    new_dir_up = dir_up;
    if (here_hit) begin
      pick_idx = cur_idx;
    end else if (dir_up) begin
      if (up_found) begin
        pick_idx = up_idx;
      end else begin
        pick_idx   = dn_idx;
        new_dir_up = 1'b0;
      end
    end else begin
      if (dn_found) begin
        pick_idx = dn_idx;
      end else begin
        pick_idx   = up_idx;
        new_dir_up = 1'b1;
      end
    end

    pick_oh = '0;
    if (any) pick_oh[pick_idx] = 1'b1;
  end

endmodule

// File: rtl/pes_elevator_scheduler.sv
// rtl/pes_elevator_scheduler.sv - SCAN call scheduler driving the elevator core with a one-hot target
module pes_elevator_scheduler
  import pes_elevator_pkg::*;
#(
  parameter int NFLOORS     = NFLOORS_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NFLOORS-1:0] call_req,
  input  logic [NFLOORS-1:0] cur_floor,
  input  logic               done,
  input  logic               hold,
  output logic [NFLOORS-1:0] target_floor,
  output logic               target_valid,
  output logic               dir_up,
  output logic [NFLOORS-1:0] pending,
  output logic               busy,
  output logic               err,
  output logic               timeout
);

  localparam int IW = (NFLOORS > 1) ? $clog2(NFLOORS) : 1;
  localparam int WW = $clog2(TIMEOUT_CYC + 1);

  state_e             state_q, state_d;
  logic [NFLOORS-1:0] pending_q, pending_d;
  logic [NFLOORS-1:0] target_q, target_d;
  logic               valid_q, valid_d;
  logic               dir_up_q, dir_up_d;
  logic               err_q, err_d;
  logic               timeout_q, timeout_d;
  logic [WW-1:0]      wdog_q, wdog_d;

  logic               cur_ok;
  logic [IW-1:0]      cur_idx;
  logic [NFLOORS-1:0] pick_oh;
  logic               pick_dir_up;
  logic               pick_any;
  logic [NFLOORS-1:0] clr;

  assign cur_ok  = onehot_ok(VEC_W'(cur_floor));
  assign cur_idx = IW'(oh_to_idx(VEC_W'(cur_floor)));

  pes_elevator_scan_pick #(
    .NFLOORS (NFLOORS),
    .IW      (IW)
  ) u_pick (
    .pending    (pending_q),
    .cur_idx    (cur_idx),
    .dir_up     (dir_up_q),
    .pick_oh    (pick_oh),
    .new_dir_up (pick_dir_up),
    .any        (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    valid_d   = valid_q;
    dir_up_d  = dir_up_q;
    timeout_d = 1'b0;
    wdog_d    = wdog_q;
    err_d     = ~cur_ok;
    // Clear applied after the OR so a call on the floor just served is absorbed.
    clr       = (state_q == ST_RETIRE) ? target_q : '0;
    pending_d = (pending_q | call_req) & ~clr;

    case (state_q)
      ST_IDLE: begin
        if (pick_any && !hold && !err_q && cur_ok) begin
          target_d = pick_oh;
          valid_d  = 1'b1;
          dir_up_d = pick_dir_up;
          wdog_d   = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (done) begin
          wdog_d  = '0;
          state_d = ST_RETIRE;
        end else if (wdog_q == WW'(TIMEOUT_CYC - 1)) begin
          timeout_d = 1'b1;
          valid_d   = 1'b0;
          target_d  = '0;
          wdog_d    = '0;
          state_d   = ST_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_RETIRE: begin
        valid_d  = 1'b0;
        target_d = '0;
        state_d  = ST_IDLE;
      end
      default: begin
        valid_d  = 1'b0;
        target_d = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      target_q  <= '0;
      valid_q   <= 1'b0;
      dir_up_q  <= 1'b1;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      target_q  <= target_d;
      valid_q   <= valid_d;
      dir_up_q  <= dir_up_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      wdog_q    <= wdog_d;
    end
  end

  assign target_floor = target_q;
  assign target_valid = valid_q;
  assign dir_up       = dir_up_q;
  assign pending      = pending_q;
  assign busy         = (state_q != ST_IDLE);
  assign err          = err_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_pes_elevator_scheduler.sv
// tb/tb_pes_elevator_scheduler.sv - directed self-checking bench for pes_elevator_scheduler
module tb_pes_elevator_scheduler;

  localparam int NF = 8;
  localparam int TO = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [NF-1:0] call_req;
  logic [NF-1:0] cur_floor;
  logic          done;
  logic          hold;
  logic [NF-1:0] target_floor;
  logic          target_valid;
  logic          dir_up;
  logic [NF-1:0] pending;
  logic          busy;
  logic          err;
  logic          timeout;

  int tests_run = 0;
  int tests_failed = 0;

  pes_elevator_scheduler #(.NFLOORS(NF), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .call_req     (call_req),
    .cur_floor    (cur_floor),
    .done         (done),
    .hold         (hold),
    .target_floor (target_floor),
    .target_valid (target_valid),
    .dir_up       (dir_up),
    .pending      (pending),
    .busy         (busy),
    .err          (err),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    reset     = 1'b0;
    call_req  = '0;
    cur_floor = 8'h01;
    done      = 1'b0;
    hold      = 1'b0;
    #12;
    check("rst_valid", 32'(target_valid), 32'h0);
    check("rst_dir", 32'(dir_up), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    tick();
    reset = 1'b1;

    // 1: single call to top floor from floor 0
    call_req = 8'h80;
    tick();
    call_req = '0;
    check("t1_pend", 32'(pending), 32'h80);
    check("t1_valid_e0", 32'(target_valid), 32'h0);
    tick();
    check("t1_valid_e1", 32'(target_valid), 32'h1);
    check("t1_target", 32'(target_floor), 32'h80);
    check("t1_dir", 32'(dir_up), 32'h1);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("t1_retire_valid", 32'(target_valid), 32'h1);
    tick();
    check("t1_pend_clr", 32'(pending), 32'h0);
    check("t1_valid_lo", 32'(target_valid), 32'h0);
    check("t1_busy_lo", 32'(busy), 32'h0);

    // 2: SCAN ordering, up first then reverse
    cur_floor = 8'h08;
    call_req  = 8'h42;
    tick();
    call_req = '0;
    tick();
    check("t2_target_up", 32'(target_floor), 32'h40);
    check("t2_dir_up", 32'(dir_up), 32'h1);
    cur_floor = 8'h40;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    check("t2_pend_left", 32'(pending), 32'h02);
    tick();
    check("t2_target_dn", 32'(target_floor), 32'h02);
    check("t2_dir_dn", 32'(dir_up), 32'h0);
    cur_floor = 8'h02;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    check("t2_pend_empty", 32'(pending), 32'h0);

    // 3: hold inhibits dispatch
    hold = 1'b1;
    call_req = 8'h10;
    tick();
    call_req = '0;
    tick();
    tick();
    check("t3_hold_valid", 32'(target_valid), 32'h0);
    check("t3_hold_pend", 32'(pending), 32'h10);
    hold = 1'b0;
    tick();
    check("t3_valid", 32'(target_valid), 32'h1);
    check("t3_target", 32'(target_floor), 32'h10);
    check("t3_dir", 32'(dir_up), 32'h1);

    // 4: watchdog abort without done, then redispatch
    n = 0;
    while (timeout !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("t4_to_cycles", 32'(n), 32'(TO));
    check("t4_valid", 32'(target_valid), 32'h0);
    check("t4_target", 32'(target_floor), 32'h0);
    check("t4_pend_kept", 32'(pending), 32'h10);
    tick();
    check("t4_to_pulse", 32'(timeout), 32'h0);
    check("t4_redisp", 32'(target_valid), 32'h1);
    check("t4_redisp_tgt", 32'(target_floor), 32'h10);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    check("t4_pend_clr", 32'(pending), 32'h0);

    // 5: invalid cur_floor blocks dispatch
    cur_floor = 8'h03;
    tick();
    check("t5_err", 32'(err), 32'h1);
    call_req = 8'h04;
    tick();
    call_req = '0;
    check("t5_pend", 32'(pending), 32'h04);
    tick();
    check("t5_no_disp", 32'(target_valid), 32'h0);
    cur_floor = 8'h02;
    tick();
    check("t5_err_clr", 32'(err), 32'h0);
    check("t5_still_idle", 32'(target_valid), 32'h0);
    tick();
    check("t5_disp", 32'(target_valid), 32'h1);
    check("t5_target", 32'(target_floor), 32'h04);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();

    // 6: async reset mid-RUN, then call on target during RETIRE
    call_req = 8'h80;
    tick();
    call_req = '0;
    tick();
    check("t6_run", 32'(target_valid), 32'h1);
    reset = 1'b0;
    #1;
    check("t6_rst_valid", 32'(target_valid), 32'h0);
    check("t6_rst_target", 32'(target_floor), 32'h0);
    check("t6_rst_pend", 32'(pending), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    tick();
    reset = 1'b1;
    call_req = 8'h20;
    tick();
    call_req = '0;
    tick();
    check("t6_target", 32'(target_floor), 32'h20);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("t6_retire_busy", 32'(busy), 32'h1);
    call_req = 8'h20;
    tick();
    call_req = '0;
    check("t6_clr_wins", 32'(pending), 32'h0);
    tick();
    check("t6_stay_clr", 32'(pending), 32'h0);
    check("t6_idle", 32'(target_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
